// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, imem request FSM and IF/ID register
// A one-entry hold buffer absorbs stalls and a saved target absorbs redirects that arrive mid-access.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wpcir,
  input  logic        clr,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_d,
  output logic [31:0] instra_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] hold_buf;
  logic [31:0] saved_pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;

  assign pc_plus4  = pc_f + 32'd4;
  assign redirect  = clr & wpcir & valid_d;
  assign imem_req  = req_q & ~rst;
  assign imem_addr = pc_f;

  always_comb begin
    target = pc_plus4;
    case (pcsrc)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      req_q      <= 1'b1;
      pc_f       <= RESET_PC;
      pc_plus4_d <= 32'd0;
      instra_d   <= NOP;
      valid_d    <= 1'b0;
      hold_buf   <= 32'd0;
      saved_pc   <= 32'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            if (redirect) begin
              pc_f     <= target;
              instra_d <= NOP;
              valid_d  <= 1'b0;
            end else if (wpcir) begin
              pc_f       <= pc_plus4;
              pc_plus4_d <= pc_plus4;
              instra_d   <= imem_rdata;
              valid_d    <= 1'b1;
            end else begin
              // Decode is stalled: park the word so the access is not repeated.
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
              req_q    <= 1'b0;
            end
          end else if (redirect) begin
            saved_pc <= target;
            instra_d <= NOP;
            valid_d  <= 1'b0;
            state    <= S_DROP;
          end else if (wpcir) begin
            instra_d <= NOP;
            valid_d  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_f     <= target;
            instra_d <= NOP;
            valid_d  <= 1'b0;
            state    <= S_REQ;
            req_q    <= 1'b1;
          end else if (wpcir) begin
            pc_f       <= pc_plus4;
            pc_plus4_d <= pc_plus4;
            instra_d   <= hold_buf;
            valid_d    <= 1'b1;
            state      <= S_REQ;
            req_q      <= 1'b1;
          end
        end
        S_DROP: begin
          // The abandoned access must still complete before the new target is fetched.
          if (imem_ready) begin
            pc_f  <= saved_pc;
            state <= S_REQ;
          end
          if (wpcir) begin
            instra_d <= NOP;
            valid_d  <= 1'b0;
          end
        end
        default: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
// Memory model returns addr ^ 32'hA5A5_0000 after a programmable number of wait states.
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, wpcir, clr;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, jpc, rpc;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_f, pc_plus4_d, instra_d;
  logic        valid_d;

  int n_tests = 0;
  int n_fail  = 0;
  int ws      = 0;
  int cnt     = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .wpcir(wpcir), .clr(clr), .pcsrc(pcsrc),
    .bpc(bpc), .jpc(jpc), .rpc(rpc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc_f(pc_f), .pc_plus4_d(pc_plus4_d), .instra_d(instra_d), .valid_d(valid_d)
  );

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  assign imem_ready = imem_req && (cnt >= ws);
  assign imem_rdata = imem_addr ^ K;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wpcir = 1'b1; clr = 1'b0; pcsrc = 2'b00;
    bpc = '0; jpc = '0; rpc = '0;
    tick(); tick();
    check("rst_pc", pc_f, 32'h0);
    check("rst_valid", {31'd0, valid_d}, 32'd0);
    check("rst_instr", instra_d, 32'h0);
    check("rst_pc4", pc_plus4_d, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);

    // zero-wait sequential fetch
    for (int k = 0; k < 4; k++) begin
      check("seq_addr", imem_addr, 32'(4 * k));
      tick();
      check("seq_instr", instra_d, 32'(4 * k) ^ K);
      check("seq_pc4", pc_plus4_d, 32'(4 * k + 4));
      check("seq_valid", {31'd0, valid_d}, 32'd1);
    end

    // stall at 0x10 for three cycles with ready high
    check("hold_addr", imem_addr, 32'h10);
    wpcir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) begin
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_frozen", instra_d, 32'hC ^ K);
      end
    end
    wpcir = 1'b1;
    tick();
    check("hold_rel_instr", instra_d, 32'h10 ^ K);
    check("hold_rel_pc4", pc_plus4_d, 32'h14);
    check("hold_next_addr", imem_addr, 32'h14);

    // two wait states
    ws = 2;
    for (int a = 0; a < 3; a++) begin
      for (int j = 0; j < 3; j++) begin
        check("ws_addr", imem_addr, 32'(32'h14 + 4 * a));
        tick();
        check("ws_valid", {31'd0, valid_d}, (j == 2) ? 32'd1 : 32'd0);
        if (j == 2) check("ws_instr", instra_d, 32'(32'h14 + 4 * a) ^ K);
      end
    end

    // branch redirect while 0x20 is still pending
    check("drop_addr0", imem_addr, 32'h20);
    clr = 1'b1; pcsrc = 2'b01; bpc = 32'h100;
    tick();
    clr = 1'b0;
    check("drop_valid0", {31'd0, valid_d}, 32'd0);
    check("drop_addr1", imem_addr, 32'h20);
    check("drop_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("drop_addr2", imem_addr, 32'h20);
    check("drop_instr", instra_d, 32'h0);
    tick();
    check("drop_target", imem_addr, 32'h100);
    check("drop_valid3", {31'd0, valid_d}, 32'd0);

    // register and jump redirects with zero-wait memory
    ws = 0;
    tick();
    check("b_instr", instra_d, 32'h100 ^ K);
    clr = 1'b1; pcsrc = 2'b10; rpc = 32'h80;
    tick();
    clr = 1'b0;
    check("jr_addr", imem_addr, 32'h80);
    check("jr_bubble", {31'd0, valid_d}, 32'd0);
    tick();
    check("jr_instr", instra_d, 32'h80 ^ K);
    check("jr_valid", {31'd0, valid_d}, 32'd1);
    clr = 1'b1; pcsrc = 2'b11; jpc = 32'h0400_0000;
    tick();
    clr = 1'b0;
    check("j_addr", imem_addr, 32'h0400_0000);
    check("j_bubble", {31'd0, valid_d}, 32'd0);
    tick();
    check("j_instr", instra_d, 32'h0400_0000 ^ K);
    check("j_next", imem_addr, 32'h0400_0004);

    // PC wrap
    clr = 1'b1; pcsrc = 2'b11; jpc = 32'hFFFF_FFFC;
    tick();
    clr = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", imem_addr, 32'h0);
    check("wrap_instr", instra_d, 32'h5A5A_FFFC);
    check("wrap_pc4", pc_plus4_d, 32'h0);

    // clr during stall is ignored
    wpcir = 1'b0; clr = 1'b1; pcsrc = 2'b01; bpc = 32'h300;
    tick();
    check("clr_stall_req", {31'd0, imem_req}, 32'd0);
    check("clr_stall_pc", pc_f, 32'h0);
    wpcir = 1'b1; clr = 1'b0;
    tick();
    check("clr_stall_instr", instra_d, K);
    check("clr_stall_addr", imem_addr, 32'h4);

    // reset while in DROP
    ws = 2;
    clr = 1'b1; pcsrc = 2'b01; bpc = 32'h200;
    tick();
    clr = 1'b0;
    check("rdrop_addr", imem_addr, 32'h4);
    rst = 1'b1;
    tick();
    check("rdrop_req", {31'd0, imem_req}, 32'd0);
    check("rdrop_pc", pc_f, 32'h0);
    check("rdrop_valid", {31'd0, valid_d}, 32'd0);
    rst = 1'b0;
    #1;
    check("rdrop_req2", {31'd0, imem_req}, 32'd1);
    tick(); tick(); tick();
    check("rdrop_instr", instra_d, K);
    check("rdrop_valid2", {31'd0, valid_d}, 32'd1);
    check("rdrop_next", imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
